// File: rtl/fmul_pow2_seq.sv
// Sequential x * 2^k for a {sign, exp, mnt} float: one exact doubling per clock, valid/ready I/O.
// Optional FMUL_POW2_FTZ_EN flushes denormal inputs to signed zero on accept.
module fmul_pow2_seq #(
  parameter int unsigned I_EXP  = 8,
  parameter int unsigned I_MNT  = 7,
  parameter int unsigned I_DATA = I_EXP + I_MNT + 1,
  parameter int unsigned K_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_DATA-1:0] in_data,
  input  logic [K_W-1:0]    in_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I_DATA-1:0] out_data,
  output logic              out_ovf
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [I_EXP-1:0] ExpMax = {I_EXP{1'b1}};
  localparam logic [I_EXP-1:0] ExpOvf = {{(I_EXP-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [I_DATA-1:0]   data_q, data_d;
  logic [K_W-1:0]      cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [I_EXP-1:0]    cur_exp, in_exp, dbl_exp;
  logic [I_MNT-1:0]    cur_mnt, in_mnt, dbl_mnt;
  logic                dbl_ovf;
  logic [I_DATA-1:0]   dbl_data;

  // Zero, infinity and NaN are fixed points of doubling.
  function automatic logic is_special(input logic [I_EXP-1:0] e, input logic [I_MNT-1:0] m);
    return (e == ExpMax) || ((e == '0) && (m == '0));
  endfunction

  assign cur_exp  = data_q[I_DATA-2:I_MNT];
  assign cur_mnt  = data_q[I_MNT-1:0];
  assign in_exp   = in_data[I_DATA-2:I_MNT];
  assign in_mnt   = in_data[I_MNT-1:0];
  assign dbl_data = {data_q[I_DATA-1], dbl_exp, dbl_mnt};

  always_comb begin
    dbl_exp = cur_exp;
    dbl_mnt = cur_mnt;
    dbl_ovf = ovf_q;
    if (cur_exp == ExpMax) begin
      dbl_exp = cur_exp;
    end else if (cur_exp == ExpOvf) begin
      dbl_exp = ExpMax;
      dbl_mnt = '0;
      dbl_ovf = 1'b1;
    end else if (cur_exp != '0) begin
      dbl_exp = cur_exp + 1'b1;
    end else begin
`ifdef FMUL_POW2_FTZ_EN
      // Only zero can reach here with flushing enabled.
      dbl_exp = cur_exp;
`else
      // Mantissa MSB shifts into the exponent when a denormal becomes normal.
      dbl_exp = {{(I_EXP-1){1'b0}}, cur_mnt[I_MNT-1]};
      dbl_mnt = cur_mnt << 1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = in_k;
          ovf_d  = 1'b0;
`ifdef FMUL_POW2_FTZ_EN
          if ((in_exp == '0) && (in_mnt != '0)) begin
            data_d = {in_data[I_DATA-1], {(I_DATA-1){1'b0}}};
            state_d = StDone;
          end else
`endif
          if ((in_k == '0) || is_special(in_exp, in_mnt)) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        data_d = dbl_data;
        ovf_d  = dbl_ovf;
        cnt_d  = cnt_q - 1'b1;
        if ((cnt_q == K_W'(1)) || is_special(dbl_exp, dbl_mnt)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule
